// File: rtl/qm_lsu.sv
// qm_lsu: memory-stage load/store unit in front of qm_dcache.
// Turns byte/half/word MIPS accesses into word-only cache cycles: lane
// extraction and extension on loads, read-modify-write on sub-word stores,
// and misaligned/reserved requests answered locally with an address error.
module qm_lsu #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_addr_error,
  output logic        cache_enable,
  output logic [31:0] cache_address,
  output logic        cache_write_enable,
  output logic [31:0] cache_write_data,
  input  logic        cache_stall,
  input  logic [31:0] cache_read_data
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

  state_t      state, state_next;
  logic        store_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        req_misaligned;
  logic        xfer;

  // Bit position of the addressed byte/half lane inside the 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    logic [4:0] sh;
    sh = 5'd0;
    if (size == 2'd0)
      sh = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
    else if (size == 2'd1)
      sh = (BIG_ENDIAN ^ off[1]) ? 5'd16 : 5'd0;
    return sh;
  endfunction

  // Pull the addressed lane down to bit 0 and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> lane_shift(size, off);
    case (size)
      2'd0:    res = {(uns ? 24'd0 : {24{lane[7]}}), lane[7:0]};
      2'd1:    res = {(uns ? 16'd0 : {16{lane[15]}}), lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of the cache word with the low bits of the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] data);
    logic [31:0] base;
    logic [4:0]  sh;
    case (size)
      2'd0:    base = 32'h0000_00FF;
      2'd1:    base = 32'h0000_FFFF;
      default: base = 32'hFFFF_FFFF;
    endcase
    sh = lane_shift(size, off);
    return (word & ~(base << sh)) | ((data & base) << sh);
  endfunction

  assign xfer = cache_enable && !cache_stall;

  // Alignment / reserved-size check on the incoming request.
  always_comb begin
    case (req_size)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = req_address[0];
      2'd2:    req_misaligned = |req_address[1:0];
      default: req_misaligned = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; every cache state waits for an unstalled enable cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_misaligned)         state_next = S_RESP;
          else if (!req_store)        state_next = S_LOAD;
          else if (req_size == 2'd2)  state_next = S_WRITE;
          else                        state_next = S_RMW_RD;
        end
      end
      S_LOAD:   if (xfer) state_next = S_RESP;
      S_RMW_RD: if (xfer) state_next = S_WRITE;
      S_WRITE:  if (xfer) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded purely from the state and latched request fields.
  always_comb begin
    req_ready          = (state == S_IDLE);
    cache_enable       = (state == S_LOAD) || (state == S_RMW_RD) || (state == S_WRITE);
    cache_write_enable = (state == S_WRITE);
    cache_address      = {addr_q[31:2], 2'b00};
    cache_write_data   = (state == S_WRITE) ? wdata_q : 32'd0;
    resp_valid         = (state == S_RESP);
    resp_addr_error    = (state == S_RESP) && err_q;
    resp_data          = ((state == S_RESP) && !store_q && !err_q) ? rdata_q : 32'd0;
  end

  // Request latch, load result capture and RMW merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            uns_q   <= req_unsigned;
            err_q   <= req_misaligned;
            size_q  <= req_size;
            addr_q  <= req_address;
            wdata_q <= req_wdata;
            rdata_q <= 32'd0;
          end
        end
        S_LOAD:   if (xfer) rdata_q <= load_extend(cache_read_data, size_q, addr_q[1:0], uns_q);
        S_RMW_RD: if (xfer) wdata_q <= merge_store(cache_read_data, size_q, addr_q[1:0], wdata_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qm_lsu.sv
// Testbench for qm_lsu (BIG_ENDIAN=1) with a small stalling cache model.
module tb_qm_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_addr_error;
  logic [31:0] resp_data;
  logic        cache_enable, cache_write_enable, cache_stall;
  logic [31:0] cache_address, cache_write_data, cache_read_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_word   = 32'd0;
  int          stall_cfg = 0;
  int          stall_cnt = 0;

  always #5 clk = ~clk;

  qm_lsu #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_addr_error(resp_addr_error), .cache_enable(cache_enable),
    .cache_address(cache_address), .cache_write_enable(cache_write_enable),
    .cache_write_data(cache_write_data), .cache_stall(cache_stall),
    .cache_read_data(cache_read_data)
  );

  // Cache model: each access is stalled for stall_cfg cycles, then completes.
  assign cache_stall     = cache_enable && (stall_cnt < stall_cfg);
  assign cache_read_data = cache_enable ? rd_word : 32'd0;
  always @(posedge clk) begin
    if (cache_enable && cache_stall) stall_cnt <= stall_cnt + 1;
    else                             stall_cnt <= 0;
  end

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic        exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[14];
  vec_t sbq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, wr_n;
    logic got, en_seen, have_prev;
    logic [31:0] wr_a, wr_d, prev_addr;
    vec_t e;
    rd_word   = v.rdata;
    stall_cfg = v.stall;
    @(negedge clk);
    req_valid    = 1'b1;
    req_store    = v.store;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_address  = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    sbq.push_back(v);
    #1 req_valid = 1'b0;
    cyc = 0; wr_n = 0; got = 1'b0; en_seen = 1'b0; have_prev = 1'b0;
    wr_a = 32'd0; wr_d = 32'd0; prev_addr = 32'd0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !v.exp_err) begin
        check($sformatf("v%0d cache_address", idx), cache_address, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d req_ready busy", idx), {31'd0, req_ready}, 32'd0);
      end
      if (cache_enable) en_seen = 1'b1;
      if (cache_enable && cache_stall) begin
        if (have_prev) check($sformatf("v%0d stall addr hold", idx), cache_address, prev_addr);
        prev_addr = cache_address;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (cache_enable && cache_write_enable && !cache_stall) begin
        wr_n++;
        wr_a = cache_address;
        wr_d = cache_write_data;
      end
      if (resp_valid) begin
        got = 1'b1;
        if (sbq.size() == 0) begin
          check($sformatf("v%0d unexpected resp", idx), 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check($sformatf("v%0d resp_data", idx), resp_data, e.exp_data);
          check($sformatf("v%0d resp_addr_error", idx), {31'd0, resp_addr_error}, {31'd0, e.exp_err});
          if (e.exp_err) begin
            check($sformatf("v%0d err latency<=2", idx), {31'd0, (cyc <= 2)}, 32'd1);
            check($sformatf("v%0d err no cache", idx), {31'd0, en_seen}, 32'd0);
          end else begin
            check($sformatf("v%0d latency", idx), cyc, e.exp_lat);
          end
        end
      end
    end
    if (!got) check($sformatf("v%0d resp timeout", idx), 32'd0, 32'd1);
    check($sformatf("v%0d write count", idx), wr_n, v.exp_wr ? 1 : 0);
    if (v.exp_wr) begin
      check($sformatf("v%0d write addr", idx), wr_a, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d write data", idx), wr_d, v.exp_wdata);
    end
  endtask

  initial begin
    int  extra_wr, extra_resp;
    //         store size uns addr          wdata         rdata         stall exp_data      err lat wr  exp_wdata
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0013, 32'h0,        32'h1122_3384, 0, 32'hFFFF_FF84, 1'b0, 2, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0013, 32'h0,        32'h1122_3384, 0, 32'h0000_0084, 1'b0, 2, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0,        32'h1122_F0AA, 0, 32'hFFFF_F0AA, 1'b0, 2, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0010, 32'h0,        32'h8001_0000, 0, 32'h0000_8001, 1'b0, 2, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0010, 32'h0,        32'h7F00_0000, 0, 32'h0000_007F, 1'b0, 2, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0021, 32'h0000_00CC, 32'h1122_3344, 0, 32'h0,        1'b0, 3, 1'b1, 32'h11CC_3344};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0022, 32'hABCD_5678, 32'h1122_3344, 0, 32'h0,        1'b0, 3, 1'b1, 32'h1122_5678};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0030, 32'hCAFE_F00D, 32'h0,        0, 32'h0,        1'b0, 2, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0,        32'h1234_5678, 0, 32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'h0000_BEEF, 32'h1234_5678, 0, 32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,        32'h1234_5678, 0, 32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,        32'hDEAD_BEEF, 5, 32'hDEAD_BEEF, 1'b0, 7, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h8000_0024, 32'h0000_0055, 32'hAABB_CCDD, 2, 32'h0,        1'b0, 7, 1'b1, 32'h55BB_CCDD};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_address = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset cache_enable", {31'd0, cache_enable}, 32'd0);
    check("reset cache_write_enable", {31'd0, cache_write_enable}, 32'd0);
    check("reset cache_address", cache_address, 32'd0);
    check("reset resp_data", resp_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset while a half-word RMW read is stalled: abandon it cleanly.
    rd_word   = 32'h1122_3344;
    stall_cfg = 20;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_address = 32'h8000_0022; req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rmw stalled enable", {31'd0, cache_enable}, 32'd1);
    check("rmw stalled read-only", {31'd0, cache_write_enable}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    check("abort cache_enable", {31'd0, cache_enable}, 32'd0);
    check("abort cache_write_enable", {31'd0, cache_write_enable}, 32'd0);
    check("abort cache_address", cache_address, 32'd0);
    check("abort cache_write_data", cache_write_data, 32'd0);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort resp_data", resp_data, 32'd0);
    reset = 1'b0;
    extra_wr = 0; extra_resp = 0;
    repeat (6) begin
      @(negedge clk);
      if (cache_enable && cache_write_enable) extra_wr++;
      if (resp_valid) extra_resp++;
    end
    check("abort no write", extra_wr, 0);
    check("abort no resp", extra_resp, 0);
    run_vec(vecs[0], 100);

    check("scoreboard drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
